seq_subtractor47_26: RTL

//  Multi-cycle unsigned subtractor. Computes Diff = A - zero_extend(B) for a wide
//  47-bit minuend and a narrow 26-bit subtrahend, CHUNK bits per clock, LSB first.
//  It is the inverse-direction partner of the 46+26 mantissa-path adder in the FP

---
 rtl/seq_subtractor47_26.sv | 137 +++++++++++++
 1 files changed

// File: rtl/seq_subtractor47_26.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_subtractor47_26 : multi-cycle unsigned A - zero_extend(B), LSB chunk first
// Revision 1.0
// ---------------------------------------------------------------------------
module seq_subtractor47_26 #(
  parameter int A_W   = 47,
  parameter int B_W   = 26,
  parameter int CHUNK = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [A_W-1:0] A,
  input  logic [B_W-1:0] B,
  output logic           busy,
  output logic           done,
  output logic [A_W-1:0] Diff,
  output logic           Borrow
);

  localparam int NCHUNK = (A_W + CHUNK - 1) / CHUNK;
  localparam int PAD_W  = NCHUNK * CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PIDX_W = (PAD_W > 1) ? $clog2(PAD_W) : 1;
  localparam int DIDX_W = (A_W > 1) ? $clog2(A_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PAD_W-1:0]   a_q, a_d;
  logic [PAD_W-1:0]   b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               brw_q, brw_d;
  logic [A_W-1:0]     diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  int                 w_base;
  logic [CHUNK-1:0]   w_a_chunk;
  logic [CHUNK-1:0]   w_b_chunk;
  logic [CHUNK:0]     w_res;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    brw_d    = brw_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = done_q;

    // Operands are zero-padded to whole chunks, so the borrow out of the last
    // padded chunk equals the borrow at bit A_W-1.
    w_base    = int'(cnt_q) * CHUNK;
    w_a_chunk = a_q[PIDX_W'(w_base) +: CHUNK];
    w_b_chunk = b_q[PIDX_W'(w_base) +: CHUNK];
    w_res     = {1'b0, w_a_chunk} - {1'b0, w_b_chunk} - (CHUNK+1)'(brw_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = PAD_W'(A);
          b_d     = PAD_W'(B);
          cnt_d   = '0;
          brw_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < CHUNK; i++) begin
          if (w_base + i < A_W) begin
            diff_d[DIDX_W'(w_base + i)] = w_res[i];
          end
        end
        brw_d = w_res[CHUNK];
        if (cnt_q == CNT_W'(NCHUNK - 1)) begin
          done_d   = 1'b1;
          borrow_d = w_res[CHUNK];
          cnt_d    = '0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      brw_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      brw_q    <= brw_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign Diff   = diff_q;
  assign Borrow = borrow_q;

endmodule
`default_nettype wire
